joypad_pad_bridge: RTL and testbench
====================================

# joypad_pad_bridge

Controller-side end of the joypad interface: polls an SNES-style serial game pad (latch/clock/data) and answers the Game Boy P1 select lines. It drives `joypad_data` in response to `joypad_sel`, the same way the original button matrix would. It sits at the top level between the external pad connector and the `joypad_sel`/`joypad_data` pins of `gameboy`, in the same `clock` domain.

## Interface
Parameters:
- `CLK_DIV`, default 200: `clock` cycles per half-period of `pad_clk`; also sets latch length (2·CLK_DIV). Minimum 4.
- `POLL_PERIOD`, default 550000: `clock` cycles from one poll start to the next. Must be ≥ 34·CLK_DIV+1.

Ports:
- `clock` in 1: single clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pad_latch` out 1: latch pulse to the pad, high during LATCH.
- `pad_clk` out 1: serial clock to the pad; idles high.
- `pad_data` in 1: serial data from the pad; active-low (0 = pressed). Asynchronous to `clock`.
- `joypad_sel` in 2: bit0 low selects the direction group; bit1 low selects the action group.
- `joypad_data` out 4: active-low P1 nibble (P10–P13).
- `buttons` out 8: active-low committed state, {Start, Select, B, A, Down, Up, Left, Right}.
- `poll_done` out 1: one-cycle pulse when a valid frame is committed.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.

## Operation
- `pad_data` passes through a 2-flop synchronizer before sampling.
- Poll counter:
  - Reset value is POLL_PERIOD−1, so the first poll starts on the first clock after reset release.
  - It reloads when a poll starts.
  - If it expires while a frame is in progress, it saturates and the next poll starts the cycle after DONE.
- FSM states: IDLE → LATCH → LOW(k) → HIGH(k) → … → DONE → IDLE.
  - IDLE: `pad_latch`=0, `pad_clk`=1. Leaves when the poll counter expires.
  - LATCH: `pad_latch`=1 for 2·CLK_DIV cycles.
  - LOW(k), k=0..15: `pad_clk`=0 for CLK_DIV cycles. The synchronized `pad_data` is shifted into bit k on the last cycle of the phase.
  - HIGH(k): `pad_clk`=1 for CLK_DIV cycles. After HIGH(15) go to DONE, otherwise go to LOW(k+1).
  - DONE: one cycle, commit or reject, then IDLE.
- SNES bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12–15 signature.
- Validity: all of bits 12–15 must read 1.
  - Valid frame: `buttons` ← {b3, b2, b0, b8, b5, b4, b6, b7} and `poll_done` pulses.
  - Invalid frame: `buttons` is held and `frame_err` pulses.
  - Y, X, L and R are ignored.
- P1 response (registered): `joypad_data` ← (sel[0] ? 4'hF : buttons[3:0]) & (sel[1] ? 4'hF : buttons[7:4]).
  - Both groups selected gives the wired-AND of the two nibbles.
  - Neither selected gives 4'hF.
- Reset values: `pad_latch`=0, `pad_clk`=1, `buttons`=8'hFF, `joypad_data`=4'hF, `poll_done`=0, `frame_err`=0, FSM=IDLE, shift register all 1s.
- Reset mid-frame: outputs go to their reset values immediately and the partial frame is discarded. The first poll after release restarts at LATCH.

## Timing
- Frame length is 34·CLK_DIV+1 cycles. The `pad_latch` rising edge is frame cycle 0, and DONE (the pulse cycle) is cycle 34·CLK_DIV.
- Sampling point: the last cycle of LOW(k), at least CLK_DIV−1 cycles after `pad_clk` falls. The pad shifts on the `pad_clk` rising edge, so the data is stable by then even with the 2-cycle synchronizer delay.
- Latency from `joypad_sel` change to `joypad_data`: exactly 1 clock.
- Latency from a `buttons` commit to `joypad_data`: 1 clock.
- If a commit and a `joypad_sel` change land on the same edge, the next `joypad_data` uses both new values.
- `poll_done` and `frame_err` are mutually exclusive and never both asserted.

## Structure
- Shared package `joypad_pkg`:
  - SNES bit index constants.
  - GB group bit positions (RIGHT=0, LEFT=1, UP=2, DOWN=3; A=0, B=1, SELECT=2, START=3).
  - Signature mask 16'hF000.
  - FSM state enum.
- Sub-module `snes_pad_reader`: synchronizer, poll counter, FSM and shift register. It outputs a 16-bit frame plus a frame_valid/frame_err strobe.
- Top `joypad_pad_bridge`: bit remap, the `buttons` register and the P1 mux.

## Test plan
Bench parameters: CLK_DIV=4, POLL_PERIOD=200. The pad model shifts on the `pad_clk` rising edge.
- Reset, then release → all outputs at their reset values while in reset. `pad_latch` rises on the first clock after release and stays high for 8 cycles. `pad_clk` then shows 16 low/high pulses of 4+4 cycles.
- Pad reports A and Up pressed (frame 16'hFEEF, bits 4 and 8 low) → `poll_done` pulses 136 cycles after the `pad_latch` rise and `buttons`=8'hEB. Then sel=2'b10 → 4'hB; sel=2'b01 → 4'hE; sel=2'b00 → 4'hA; sel=2'b11 → 4'hF.
- Frame with bit 13 low → `frame_err` pulses, `poll_done` stays 0, `buttons` keeps its prior value of 8'hEB.
- Assert `reset_n` low during LOW(6) → asynchronously `pad_latch`=0, `pad_clk`=1, `buttons`=8'hFF. After release, a fresh LATCH starts on the next clock.
- Free-running polls → successive `pad_latch` rising edges are exactly 200 cycles apart, with exactly one `poll_done` or `frame_err` per frame.
- Toggle `joypad_sel` every cycle with `buttons`=8'h5A → `joypad_data` tracks the mux result with exactly 1-cycle lag.

Source files
------------

// File: rtl/joypad_pkg.sv
// joypad_pkg: constants and types shared by the SNES pad reader and the
// Game Boy P1 bridge.
//   - SNES serial bit positions for the buttons the Game Boy can use
//     (Y, X, L and R are read off the wire but never mapped).
//   - Game Boy group bit positions inside each P1 nibble.
//   - Signature mask: a genuine pad always shifts out 1s in bits 12-15.
//   - Reader FSM state enum.
//   - remap_frame: SNES frame -> active-low {action, direction} byte.
package joypad_pkg;

    localparam int SNES_B      = 0;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;

    // Direction group (low nibble of buttons)
    localparam int GB_RIGHT  = 0;
    localparam int GB_LEFT   = 1;
    localparam int GB_UP     = 2;
    localparam int GB_DOWN   = 3;
    // Action group (high nibble of buttons)
    localparam int GB_A      = 0;
    localparam int GB_B      = 1;
    localparam int GB_SELECT = 2;
    localparam int GB_START  = 3;

    localparam logic [15:0] SIG_MASK = 16'hF000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Both sides are active-low, so this is a pure bit permutation.
    function automatic logic [7:0] remap_frame(input logic [15:0] frame);
        logic [7:0] b;
        b = 8'hFF;
        b[4 + GB_START]  = frame[SNES_START];
        b[4 + GB_SELECT] = frame[SNES_SELECT];
        b[4 + GB_B]      = frame[SNES_B];
        b[4 + GB_A]      = frame[SNES_A];
        b[GB_DOWN]       = frame[SNES_DOWN];
        b[GB_UP]         = frame[SNES_UP];
        b[GB_LEFT]       = frame[SNES_LEFT];
        b[GB_RIGHT]      = frame[SNES_RIGHT];
        return b;
    endfunction

endpackage

// File: rtl/joypad_pad_bridge_snes_pad_reader.sv
// snes_pad_reader: polls an SNES pad over latch/clock/data.
//   clock, reset_n : clock and async active-low reset
//   pad_data       : serial data from the pad (async, active-low)
//   pad_latch      : latch pulse, 2*CLK_DIV cycles
//   pad_clk        : serial clock, idles high, CLK_DIV low + CLK_DIV high per bit
//   frame          : 16 bits shifted in during the current/last poll
//   frame_valid    : one-cycle strobe in DONE when bits 12-15 all read 1
//   frame_err      : one-cycle strobe in DONE when the signature is wrong
//   state          : FSM state, for debug visibility
module snes_pad_reader
    import joypad_pkg::*;
#(
    parameter int CLK_DIV     = 200,
    parameter int POLL_PERIOD = 550000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] frame,
    output logic        frame_valid,
    output logic        frame_err,
    output state_t      state
);

    localparam int PH_W   = $clog2(2 * CLK_DIV);
    localparam int POLL_W = $clog2(POLL_PERIOD);
    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]   PHASE_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_MAX   = POLL_W'(POLL_PERIOD - 1);

    logic [1:0]        sync_q;
    logic              data_s;
    logic [POLL_W-1:0] poll_cnt;
    logic              poll_expired;
    logic              poll_start;
    logic [PH_W-1:0]   ph_cnt;
    logic [3:0]        bit_idx;
    logic [15:0]       shreg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], pad_data};
    end
    assign data_s = sync_q[1];

    // A poll may start from IDLE, or straight out of DONE when the counter
    // expired (and saturated) while the previous frame was still running.
    assign poll_expired = (poll_cnt == POLL_MAX);
    assign poll_start   = poll_expired && (state == ST_IDLE || state == ST_DONE);

    // Reset value is the terminal count so the first poll begins on the
    // first clock after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          poll_cnt <= POLL_MAX;
        else if (poll_start)   poll_cnt <= '0;
        else if (!poll_expired) poll_cnt <= poll_cnt + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ph_cnt      <= '0;
            bit_idx     <= '0;
            shreg       <= '1;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b1;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    pad_clk <= 1'b1;
                    if (poll_start) begin
                        state     <= ST_LATCH;
                        pad_latch <= 1'b1;
                        ph_cnt    <= '0;
                        shreg     <= '1;
                    end else begin
                        state     <= ST_IDLE;
                        pad_latch <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (ph_cnt == LATCH_LAST) begin
                        state     <= ST_LOW;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                        ph_cnt    <= '0;
                        bit_idx   <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    // Sample on the last low cycle: the pad changed data on
                    // the previous rising edge, long past the synchronizer.
                    if (ph_cnt == PHASE_LAST) begin
                        shreg[bit_idx] <= data_s;
                        state          <= ST_HIGH;
                        pad_clk        <= 1'b1;
                        ph_cnt         <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (ph_cnt == PHASE_LAST) begin
                        ph_cnt <= '0;
                        if (bit_idx == 4'd15) begin
                            // Strobes are registered so they sit in the DONE cycle.
                            state <= ST_DONE;
                            if ((shreg & SIG_MASK) == SIG_MASK) frame_valid <= 1'b1;
                            else                                frame_err   <= 1'b1;
                        end else begin
                            state   <= ST_LOW;
                            pad_clk <= 1'b0;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b1;
                end
            endcase
        end
    end

    assign frame = shreg;

endmodule

// File: rtl/joypad_pad_bridge.sv
// joypad_pad_bridge: SNES pad in, Game Boy P1 select/data out.
//   clock, reset_n       : clock and async active-low reset
//   pad_latch, pad_clk   : outputs to the SNES pad
//   pad_data             : serial data from the pad (active-low)
//   joypad_sel[1:0]      : bit0 low = direction group, bit1 low = action group
//   joypad_data[3:0]     : active-low P1 nibble, registered
//   buttons[7:0]         : committed {Start,Select,B,A,Down,Up,Left,Right}, active-low
//   poll_done, frame_err : one-cycle strobes for accepted / rejected frames
//   debug_state          : reader FSM state
module joypad_pad_bridge
    import joypad_pkg::*;
#(
    parameter int CLK_DIV     = 200,
    parameter int POLL_PERIOD = 550000
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data,
    input  logic [1:0] joypad_sel,
    output logic [3:0] joypad_data,
    output logic [7:0] buttons,
    output logic       poll_done,
    output logic       frame_err,
    output state_t     debug_state
);

    logic [15:0] frame;
    logic        frame_valid;
    logic [7:0]  buttons_next;

    snes_pad_reader #(
        .CLK_DIV     (CLK_DIV),
        .POLL_PERIOD (POLL_PERIOD)
    ) u_reader (
        .clock       (clock),
        .reset_n     (reset_n),
        .pad_data    (pad_data),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .state       (debug_state)
    );

    assign poll_done    = frame_valid;
    assign buttons_next = frame_valid ? remap_frame(frame) : buttons;

    // The P1 mux looks at buttons_next so a commit and a select change on
    // the same edge both show up in the very next joypad_data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buttons     <= 8'hFF;
            joypad_data <= 4'hF;
        end else begin
            buttons     <= buttons_next;
            joypad_data <= (joypad_sel[0] ? 4'hF : buttons_next[3:0]) &
                           (joypad_sel[1] ? 4'hF : buttons_next[7:4]);
        end
    end

endmodule

// File: tb/tb_joypad_pad_bridge.sv
// Directed bench for joypad_pad_bridge with CLK_DIV=4, POLL_PERIOD=200.
// A behavioural SNES pad shifts pad_frame out LSB first, advancing on each
// pad_clk rising edge and restarting on pad_latch.
module tb_joypad_pad_bridge;
    import joypad_pkg::*;

    localparam int CLK_DIV     = 4;
    localparam int POLL_PERIOD = 200;
    localparam int FRAME_LEN   = 34 * CLK_DIV;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pad_latch, pad_clk, pad_data;
    logic [1:0] joypad_sel = 2'b11;
    logic [3:0] joypad_data;
    logic [7:0] buttons;
    logic       poll_done, frame_err;
    state_t     debug_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    joypad_pad_bridge #(
        .CLK_DIV     (CLK_DIV),
        .POLL_PERIOD (POLL_PERIOD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .pad_data    (pad_data),
        .joypad_sel  (joypad_sel),
        .joypad_data (joypad_data),
        .buttons     (buttons),
        .poll_done   (poll_done),
        .frame_err   (frame_err),
        .debug_state (debug_state)
    );

    // ---------------- pad model ----------------
    logic [15:0] pad_frame = 16'hFFFF;
    int          pad_idx = 0;

    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch)         pad_idx = 0;
        else if (pad_idx < 16) pad_idx = pad_idx + 1;
    end
    assign pad_data = (pad_idx < 16) ? pad_frame[pad_idx] : 1'b0;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (poll_done) done_cnt++;
            if (frame_err) err_cnt++;
            if (poll_done && frame_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // P1 nibble for buttons 8'h5A, worked out by hand per select value.
    function automatic logic [3:0] nib_5a(input logic [1:0] s);
        case (s)
            2'b00:   return 4'h0;
            2'b01:   return 4'h5;
            2'b10:   return 4'hA;
            default: return 4'hF;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_latch_rise(output int t, output bit ok);
        logic prev;
        prev = pad_latch;
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (pad_latch && !prev) begin
                ok = 1'b1;
                t = cyc;
            end
            prev = pad_latch;
        end
        if (!ok) timeout_fail("latch_wait");
    endtask

    task automatic wait_pulse(output int t, output bit ok);
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (poll_done || frame_err) begin
                ok = 1'b1;
                t = cyc;
            end
        end
        if (!ok) timeout_fail("pulse_wait");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0, t1, t2, t3, tp, n, lo, hi, good, e0, e1, falls;
        bit ok;
        logic [1:0] s;
        logic prev;

        // Reset values while held in reset
        repeat (3) @(negedge clock);
        check("rst_latch", pad_latch, 1'b0);
        check("rst_clk", pad_clk, 1'b1);
        check("rst_buttons", buttons, 8'hFF);
        check("rst_jdata", joypad_data, 4'hF);
        check("rst_done", poll_done, 1'b0);
        check("rst_err", frame_err, 1'b0);

        // Frame 1: A and Up pressed
        pad_frame = 16'hFEEF;
        exp_q.push_back(8'hEB);
        reset_n = 1'b1;
        @(negedge clock);
        check("latch_first_clk", pad_latch, 1'b1);
        t0 = cyc;
        n = 0;
        while (pad_latch && n < 20) begin
            n++;
            @(negedge clock);
        end
        check("latch_len", 16'(n), 16'(2 * CLK_DIV));
        good = 0;
        for (int k = 0; k < 16; k++) begin
            lo = 0;
            while (!pad_clk && lo < 20) begin
                lo++;
                @(negedge clock);
            end
            hi = CLK_DIV;
            if (k < 15) begin
                hi = 0;
                while (pad_clk && hi < 20) begin
                    hi++;
                    @(negedge clock);
                end
            end
            if (lo == CLK_DIV && hi == CLK_DIV) good++;
        end
        check("clk_pulses", 16'(good), 16'd16);
        wait_pulse(tp, ok);
        if (ok) begin
            check("done_latency", 16'(tp - t0), 16'(FRAME_LEN));
            check("f1_done", poll_done, 1'b1);
            check("f1_no_err", frame_err, 1'b0);
            @(negedge clock);
            check("f1_buttons", buttons, exp_q.pop_front());
            check("f1_jdata_sel11", joypad_data, 4'hF);
        end

        // P1 mux with buttons = EB
        joypad_sel = 2'b10; exp_q.push_back(8'h0B);
        @(negedge clock); check("sel10", joypad_data, exp_q.pop_front());
        joypad_sel = 2'b01; exp_q.push_back(8'h0E);
        @(negedge clock); check("sel01", joypad_data, exp_q.pop_front());
        joypad_sel = 2'b00; exp_q.push_back(8'h0A);
        @(negedge clock); check("sel00", joypad_data, exp_q.pop_front());
        joypad_sel = 2'b11; exp_q.push_back(8'h0F);
        @(negedge clock); check("sel11", joypad_data, exp_q.pop_front());

        // Frame 2: signature bit 13 low -> rejected
        pad_frame = 16'hDFFF;
        wait_pulse(tp, ok);
        if (ok) begin
            check("f2_err", frame_err, 1'b1);
            check("f2_no_done", poll_done, 1'b0);
            @(negedge clock);
            check("f2_buttons_held", buttons, 8'hEB);
        end

        // Frame 3: buttons become 5A
        pad_frame = 16'hFF66;
        exp_q.push_back(8'h5A);
        wait_pulse(tp, ok);
        if (ok) begin
            check("f3_done", poll_done, 1'b1);
            @(negedge clock);
            check("f3_buttons", buttons, exp_q.pop_front());
        end

        // Toggle select every cycle
        s = joypad_sel;
        for (int i = 0; i < 16; i++) begin
            s = s ^ 2'($urandom_range(1, 3));
            joypad_sel = s;
            exp_q.push_back({4'h0, nib_5a(s)});
            @(negedge clock);
            check("sel_toggle", joypad_data, exp_q.pop_front());
        end
        joypad_sel = 2'b11;

        // Free-running poll period and one event per frame
        wait_latch_rise(t1, ok);
        e0 = done_cnt + err_cnt;
        wait_latch_rise(t2, ok);
        e1 = done_cnt + err_cnt;
        check("period_1", 16'(t2 - t1), 16'(POLL_PERIOD));
        check("events_1", 16'(e1 - e0), 16'd1);
        wait_latch_rise(t3, ok);
        e0 = done_cnt + err_cnt;
        check("period_2", 16'(t3 - t2), 16'(POLL_PERIOD));
        check("events_2", 16'(e0 - e1), 16'd1);

        // Reset during LOW(6)
        falls = 0;
        prev = pad_clk;
        for (int i = 0; i < 200 && falls < 7; i++) begin
            @(negedge clock);
            if (!pad_clk && prev) falls++;
            prev = pad_clk;
        end
        check("reached_low6", 16'(falls), 16'd7);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_latch", pad_latch, 1'b0);
        check("midrst_clk", pad_clk, 1'b1);
        check("midrst_buttons", buttons, 8'hFF);
        check("midrst_jdata", joypad_data, 4'hF);
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back(8'h5A);
        @(negedge clock);
        check("relatch_first_clk", pad_latch, 1'b1);
        t0 = cyc;
        wait_pulse(tp, ok);
        if (ok) begin
            check("f4_latency", 16'(tp - t0), 16'(FRAME_LEN));
            check("f4_done", poll_done, 1'b1);
            @(negedge clock);
            check("f4_buttons", buttons, exp_q.pop_front());
        end

        check("done_err_exclusive", 16'(both_cnt), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
